// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - shared types and constants for the LED PIO arbiter
package led_pio_pkg;

   localparam int         LED_WIDTH_DEFAULT = 10;
   localparam logic [1:0] LED_PIO_DATA_ADDR = 2'd0;

   typedef logic [LED_WIDTH_DEFAULT-1:0] led_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DWELL = 2'd2
   } state_t;

   // Dwell counter must hold DWELL_CYCLES-1; never narrower than one bit.
   function automatic int dwell_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/led_pio_arbiter_rr_arb2.sv
// rtl/led_pio_arbiter_rr_arb2.sv - two-way round-robin grant with last-owner pointer
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic update,
   output logic grant_valid,
   output logic grant,
   output logic last_owner
);

   always_comb begin
      grant_valid = req0 | req1;
      grant       = 1'b0;
      if (req0 && req1) begin
         grant = ~last_owner;
      end else if (req1) begin
         grant = 1'b1;
      end
   end

   // Pointer resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner <= 1'b1;
      end else if (update && grant_valid) begin
         last_owner <= grant;
      end
   end

endmodule

// File: rtl/led_pio_arbiter.sv
// rtl/led_pio_arbiter.sv - shares one LED PIO register between two requesters
// with round-robin grant, optional duplicate suppression and post-write dwell.
module led_pio_arbiter
   import led_pio_pkg::*;
#(
   parameter int         LED_WIDTH    = 10,
   parameter logic [1:0] LED_ADDR     = LED_PIO_DATA_ADDR,
   parameter int         DWELL_CYCLES = 5000000,
   parameter int         SKIP_SAME    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0,
   input  logic [LED_WIDTH-1:0] data0,
   output logic                 ack0,
   input  logic                 req1,
   input  logic [LED_WIDTH-1:0] data1,
   output logic                 ack1,
   output logic [1:0]           avm_address,
   output logic                 avm_chipselect,
   output logic                 avm_write_n,
   output logic [31:0]          avm_writedata,
   input  logic                 avm_waitrequest,
   output logic                 busy,
   output logic                 last_owner
);

   localparam int            DW         = dwell_width(DWELL_CYCLES);
   localparam logic [DW-1:0] DWELL_LOAD = DW'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

   state_t               state, state_next;
   logic                 done, done_next;
   logic [LED_WIDTH-1:0] cur_data, cur_data_next;
   logic [LED_WIDTH-1:0] last_data, last_data_next;
   logic [LED_WIDTH-1:0] picked;
   logic [DW-1:0]        dwell_cnt, dwell_next;
   logic                 cs_next, write_n_next;
   logic [31:0]          wdata_next;
   logic                 ack0_next, ack1_next, busy_next;
   logic                 arb_update, grant_valid, grant;

   rr_arb2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .update      (arb_update),
      .grant_valid (grant_valid),
      .grant       (grant),
      .last_owner  (last_owner)
   );

   // WRITE has two phases: strobing (done=0) and the ack cycle (done=1).
   // A suppressed duplicate goes straight to the ack phase with no strobes.
   always_comb begin
      state_next     = state;
      done_next      = done;
      cur_data_next  = cur_data;
      last_data_next = last_data;
      dwell_next     = dwell_cnt;
      cs_next        = avm_chipselect;
      write_n_next   = avm_write_n;
      wdata_next     = avm_writedata;
      ack0_next      = 1'b0;
      ack1_next      = 1'b0;
      arb_update     = 1'b0;
      picked         = grant ? data1 : data0;

      case (state)
         IDLE: begin
            if (grant_valid) begin
               arb_update    = 1'b1;
               cur_data_next = picked;
               state_next    = WRITE;
               if (SKIP_SAME != 0 && picked == last_data) begin
                  done_next = 1'b1;
                  ack0_next = ~grant;
                  ack1_next = grant;
               end else begin
                  done_next    = 1'b0;
                  cs_next      = 1'b1;
                  write_n_next = 1'b0;
                  wdata_next   = 32'(picked);
               end
            end
         end
         WRITE: begin
            if (done) begin
               if (DWELL_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next = DWELL;
                  dwell_next = DWELL_LOAD;
               end
            end else if (!avm_waitrequest) begin
               cs_next        = 1'b0;
               write_n_next   = 1'b1;
               done_next      = 1'b1;
               last_data_next = cur_data;
               ack0_next      = ~last_owner;
               ack1_next      = last_owner;
            end
         end
         DWELL: begin
            if (dwell_cnt == '0) begin
               state_next = IDLE;
            end else begin
               dwell_next = dwell_cnt - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         done           <= 1'b0;
         cur_data       <= '0;
         last_data      <= '0;
         dwell_cnt      <= '0;
         avm_address    <= LED_ADDR;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= '0;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_next;
         done           <= done_next;
         cur_data       <= cur_data_next;
         last_data      <= last_data_next;
         dwell_cnt      <= dwell_next;
         avm_address    <= LED_ADDR;
         avm_chipselect <= cs_next;
         avm_write_n    <= write_n_next;
         avm_writedata  <= wdata_next;
         ack0           <= ack0_next;
         ack1           <= ack1_next;
         busy           <= busy_next;
      end
   end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// tb/tb_led_pio_arbiter.sv - self-checking bench for led_pio_arbiter
module tb_led_pio_arbiter;
   import led_pio_pkg::*;

   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, ack0, ack1;
   led_t        data0, data1;
   logic [1:0]  avm_address;
   logic        avm_chipselect, avm_write_n, avm_waitrequest;
   logic [31:0] avm_writedata;
   logic        busy, last_owner;

   int errors = 0;
   int checks = 0;

   // Reference state: who was served last and what the LEDs currently show.
   bit   m_owner;
   led_t m_last;

   always #5 clk = ~clk;

   led_pio_arbiter #(
      .LED_WIDTH    (10),
      .LED_ADDR     (2'd0),
      .DWELL_CYCLES (DWELL),
      .SKIP_SAME    (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req0            (req0),
      .data0           (data0),
      .ack0            (ack0),
      .req1            (req1),
      .data1           (data1),
      .ack1            (ack1),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write_n     (avm_write_n),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .last_owner      (last_owner)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_pick(input bit r0, input bit r1);
      if (r0 && r1) return !m_owner;
      return r1;
   endfunction

   // Entered at an IDLE sample point with requests already driven.
   task automatic run_service(input int stall, input bit hold, input int raise1_at,
                              input int drop1_at, input led_t late1);
      bit   g, skip;
      led_t d;
      logic gack, oack;
      g    = model_pick(req0, req1);
      d    = g ? data1 : data0;
      skip = (d == m_last);
      avm_waitrequest = 1'($urandom_range(0, 1));
      step;
      gack = g ? ack1 : ack0;
      oack = g ? ack0 : ack1;
      if (skip) begin
         checks++;
         if ({avm_chipselect, avm_write_n, gack, oack, busy} !== 5'b01101)
            $display("FAIL skip_ack: cs,wn,ack_g,ack_o,busy got %b expected 01101", {avm_chipselect, avm_write_n, gack, oack, busy});
      end else begin
         checks++;
         if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1, busy} !== {1'b1, 1'b0, 2'd0, 32'(d), 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL write_start: cs=%b wn=%b addr=%0d wd=%h ack=%b%b busy=%b expected cs=1 wn=0 addr=0 wd=%h",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1, busy, 32'(d));
         end
         for (int i = 0; i < stall; i++) begin
            avm_waitrequest = 1'b1;
            step;
            checks++;
            if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1} !== {1'b1, 1'b0, 2'd0, 32'(d), 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL write_stall: cycle %0d cs=%b wn=%b addr=%0d wd=%h ack=%b%b expected held write of %h",
                        i, avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1, 32'(d));
            end
         end
         avm_waitrequest = 1'b0;
         step;
         gack = g ? ack1 : ack0;
         oack = g ? ack0 : ack1;
         checks++;
         if ({avm_chipselect, avm_write_n, gack, oack, busy} !== 5'b01101) begin
            errors++;
            $display("FAIL write_ack: cs,wn,ack_g,ack_o,busy got %b expected 01101", {avm_chipselect, avm_write_n, gack, oack, busy});
         end
      end
      if (skip) begin
         if ({avm_chipselect, avm_write_n, gack, oack, busy} !== 5'b01101) errors++;
      end
      checks++;
      if (last_owner !== g) begin
         errors++;
         $display("FAIL last_owner: got %b expected %b", last_owner, g);
      end
      m_owner = g;
      m_last  = d;
      if (hold) begin
         if (g) data1 = led_t'($urandom);
         else   data0 = led_t'($urandom);
      end else begin
         if (g) req1 = 1'b0;
         else   req0 = 1'b0;
      end
      for (int i = 0; i < DWELL; i++) begin
         avm_waitrequest = 1'($urandom_range(0, 1));
         step;
         checks++;
         if ({avm_chipselect, avm_write_n, ack0, ack1, busy} !== 5'b01001) begin
            errors++;
            $display("FAIL dwell: cycle %0d cs,wn,ack0,ack1,busy got %b expected 01001", i, {avm_chipselect, avm_write_n, ack0, ack1, busy});
         end
         if (i == raise1_at) begin
            req1  = 1'b1;
            data1 = late1;
         end
         if (i == drop1_at) req1 = 1'b0;
      end
      step;
      checks++;
      if ({busy, avm_chipselect, ack0, ack1} !== 4'b0000) begin
         errors++;
         $display("FAIL idle: busy,cs,ack0,ack1 got %b expected 0000", {busy, avm_chipselect, ack0, ack1});
      end
   endtask

   task automatic test_reset;
      step;
      step;
      checks++;
      if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1, busy, last_owner} !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset: cs=%b wn=%b addr=%0d wd=%h ack=%b%b busy=%b last_owner=%b expected 0 1 0 0 00 0 1",
                  avm_chipselect, avm_write_n, avm_address, avm_writedata, ack0, ack1, busy, last_owner);
      end
      m_owner = 1'b1;
      m_last  = '0;
      reset   = 1'b0;
   endtask

   task automatic test_simultaneous;
      req0  = 1'b1;
      req1  = 1'b1;
      data0 = 10'h001;
      data1 = 10'h200;
      for (int k = 0; k < 4; k++) run_service(0, 1'b1, -1, -1, '0);
      req0 = 1'b0;
      req1 = 1'b0;
      step;
   endtask

   task automatic test_single;
      req0  = 1'b1;
      data0 = 10'h155;
      run_service(0, 1'b0, -1, -1, '0);
   endtask

   task automatic test_dwell_blocking;
      req0  = 1'b1;
      data0 = led_t'($urandom);
      run_service(0, 1'b0, 1, -1, led_t'($urandom));
      run_service(0, 1'b0, -1, -1, '0);
      req0  = 1'b1;
      data0 = led_t'($urandom);
      run_service(0, 1'b0, DWELL - 1, -1, led_t'($urandom));
      run_service(0, 1'b0, -1, -1, '0);
   endtask

   task automatic test_waitrequest;
      req0  = 1'b1;
      data0 = ~m_last;
      run_service(5, 1'b0, -1, -1, '0);
   endtask

   task automatic test_skip_same;
      req0  = 1'b1;
      data0 = 10'h0F0;
      run_service(0, 1'b0, -1, -1, '0);
      req1  = 1'b1;
      data1 = 10'h0F0;
      run_service(0, 1'b0, -1, -1, '0);
      req0  = 1'b1;
      data0 = 10'h0F1;
      run_service(0, 1'b0, -1, -1, '0);
   endtask

   task automatic test_withdraw;
      req0  = 1'b1;
      data0 = ~m_last;
      run_service(0, 1'b0, 0, 2, led_t'($urandom));
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if ({busy, avm_chipselect, ack0, ack1} !== 4'b0000) begin
            errors++;
            $display("FAIL withdraw: busy,cs,ack0,ack1 got %b expected 0000", {busy, avm_chipselect, ack0, ack1});
         end
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 16; k++) begin
         if (!req0 && !req1) begin
            if ($urandom_range(0, 2) != 1) begin
               req0  = 1'b1;
               data0 = ($urandom_range(0, 3) == 0) ? m_last : led_t'($urandom);
            end
            if (!req0 || $urandom_range(0, 1) == 1) begin
               req1  = 1'b1;
               data1 = ($urandom_range(0, 3) == 0) ? m_last : led_t'($urandom);
            end
         end
         run_service($urandom_range(0, 3), 1'b0, -1, -1, '0);
      end
      if (req0 || req1) run_service(0, 1'b0, -1, -1, '0);
   endtask

   task automatic test_reset_mid_write;
      req0            = 1'b1;
      data0           = (m_last != 10'h2C3) ? 10'h2C3 : 10'h13C;
      avm_waitrequest = 1'b0;
      step;
      avm_waitrequest = 1'b1;
      step;
      checks++;
      if ({avm_chipselect, avm_write_n} !== 2'b10) begin
         errors++;
         $display("FAIL pre_reset_write: cs,wn got %b expected 10", {avm_chipselect, avm_write_n});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({avm_chipselect, avm_write_n, avm_writedata, ack0, ack1, busy, last_owner} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: cs=%b wn=%b wd=%h ack=%b%b busy=%b last_owner=%b expected 0 1 0 00 0 1",
                  avm_chipselect, avm_write_n, avm_writedata, ack0, ack1, busy, last_owner);
      end
      m_owner = 1'b1;
      m_last  = '0;
      #1 reset = 1'b0;
      avm_waitrequest = 1'b0;
      run_service(1, 1'b0, -1, -1, '0);
   endtask

   initial begin
      reset           = 1'b1;
      req0            = 1'b0;
      req1            = 1'b0;
      data0           = '0;
      data1           = '0;
      avm_waitrequest = 1'b0;
      test_reset;
      test_simultaneous;
      test_single;
      test_dwell_blocking;
      test_waitrequest;
      test_skip_same;
      test_withdraw;
      test_random;
      test_reset_mid_write;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
